sprite_mem_loader: RTL and testbench

- Write-side counterpart of the VGA sprite fetch path. VGA_sprite blocks read sprite memory; this block fills it.
- A host (NIOS, Avalon-MM) programs a base address and sprite dimensions through CSRs, then streams pixels over a valid/ready port.
- The block writes each pixel to sprite memory at base + row-major linear index, the same addressing the VGA-side reader uses (width*y + x).
- It reports busy/done/error and can raise an interrupt.

---
 rtl/sprite_mem_loader_if.sv | 41 ++++
 rtl/sprite_mem_loader.sv | 184 ++++++++++++++++++
 tb/tb_sprite_mem_loader.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_mem_loader_if.sv
// Sprite loader bus bundle: Avalon-MM CSR port, pixel stream port,
// sprite memory write port and status outputs.
//
// Pixel stream handshake: a beat transfers on a rising clock edge where
// Pix_Valid and Pix_Ready are both high. The source holds Pix_Data stable
// while Pix_Valid is high and not yet accepted. Pix_Ready never depends on
// Pix_Valid.
interface sprite_mem_loader_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
);
  logic [1:0]        AVL_CSR_Address;
  logic              AVL_CSR_Read;
  logic              AVL_CSR_Write;
  logic [31:0]       AVL_CSR_WriteData;
  logic [31:0]       AVL_CSR_ReadData;
  logic              Pix_Valid;
  logic [DATA_W-1:0] Pix_Data;
  logic              Pix_Ready;
  logic [ADDR_W-1:0] MEM_Addr;
  logic [DATA_W-1:0] MEM_WriteData;
  logic              MEM_Write;
  logic              Busy;
  logic              IRQ;

  // Loader side
  modport slave (
    input  AVL_CSR_Address, AVL_CSR_Read, AVL_CSR_Write, AVL_CSR_WriteData,
    input  Pix_Valid, Pix_Data,
    output AVL_CSR_ReadData, Pix_Ready, MEM_Addr, MEM_WriteData, MEM_Write,
    output Busy, IRQ
  );

  // Host / stream source / memory side
  modport master (
    output AVL_CSR_Address, AVL_CSR_Read, AVL_CSR_Write, AVL_CSR_WriteData,
    output Pix_Valid, Pix_Data,
    input  AVL_CSR_ReadData, Pix_Ready, MEM_Addr, MEM_WriteData, MEM_Write,
    input  Busy, IRQ
  );
endinterface

// File: rtl/sprite_mem_loader.sv
// Sprite memory loader: host programs base/size over CSRs, then streams
// pixels which are written row-major at base + linear index, one memory
// write per accepted pixel, one cycle after its handshake.
module sprite_mem_loader #(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 16,
  parameter int MEM_DEPTH = 4096
) (
  input  logic                Clk,
  input  logic                Reset_n,
  sprite_mem_loader_if.slave  bus,
  output logic [1:0]          dbg_state
);
  localparam int CNT_W = ADDR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_LOAD, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d, wbase_q, wbase_d;
  logic [15:0]       width_q, width_d, height_q, height_d;
  logic [15:0]       wwidth_q, wwidth_d, wheight_q, wheight_d;
  logic [CNT_W-1:0]  total_q, total_d, count_q, count_d;
  logic              irq_en_q, irq_en_d, done_q, done_d, error_q, error_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [31:0]       rdata_q, rdata_d;

  logic              busy, pix_ready, hs, start_req, abort_req;
  logic [31:0]       total32, status;
  logic [32:0]       end_sum;
  logic [CNT_W-1:0]  count_inc;

  // Decode strobes, handshake and sizing arithmetic
  always_comb begin
    pix_ready = (state_q == S_LOAD);
    busy      = (state_q != S_IDLE) || wr_q;
    hs        = bus.Pix_Valid && pix_ready;
    abort_req = bus.AVL_CSR_Write && (bus.AVL_CSR_Address == 2'd0) &&
                bus.AVL_CSR_WriteData[1];
    start_req = bus.AVL_CSR_Write && (bus.AVL_CSR_Address == 2'd0) &&
                bus.AVL_CSR_WriteData[0] && !bus.AVL_CSR_WriteData[1];
    total32   = 32'(wwidth_q) * 32'(wheight_q);
    end_sum   = 33'(wbase_q) + 33'(total32);
    count_inc = count_q + CNT_W'(1);
    status    = '0;
    status[0] = busy;
    status[1] = done_q;
    status[2] = error_q;
    status[16 +: ADDR_W] = count_q[ADDR_W-1:0];
  end

  // CSR updates, FSM next state and write pipeline
  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    width_d   = width_q;
    height_d  = height_q;
    wbase_d   = wbase_q;
    wwidth_d  = wwidth_q;
    wheight_d = wheight_q;
    total_d   = total_q;
    count_d   = count_q;
    irq_en_d  = irq_en_q;
    done_d    = done_q;
    error_d   = error_q;
    wr_d      = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    rdata_d   = rdata_q;

    if (bus.AVL_CSR_Write) begin
      case (bus.AVL_CSR_Address)
        2'd0: irq_en_d = bus.AVL_CSR_WriteData[2];
        2'd1: if (!busy) base_d = bus.AVL_CSR_WriteData[ADDR_W-1:0];
        2'd2: if (!busy) begin
          width_d  = bus.AVL_CSR_WriteData[15:0];
          height_d = bus.AVL_CSR_WriteData[31:16];
        end
        default: begin
          if (bus.AVL_CSR_WriteData[1]) done_d  = 1'b0;
          if (bus.AVL_CSR_WriteData[2]) error_d = 1'b0;
        end
      endcase
    end

    if (bus.AVL_CSR_Read) begin
      case (bus.AVL_CSR_Address)
        2'd0:    rdata_d = {29'd0, irq_en_q, 2'b00};
        2'd1:    rdata_d = 32'(base_q);
        2'd2:    rdata_d = {height_q, width_q};
        default: rdata_d = status;
      endcase
    end

    case (state_q)
      S_IDLE: begin
        if (start_req) begin
          state_d   = S_CHECK;
          done_d    = 1'b0;
          error_d   = 1'b0;
          count_d   = '0;
          wbase_d   = base_q;
          wwidth_d  = width_q;
          wheight_d = height_q;
        end
      end
      S_CHECK: begin
        if (abort_req) begin
          state_d = S_IDLE;
        end else if (wwidth_q == 16'd0 || wheight_q == 16'd0 ||
                     end_sum > 33'(MEM_DEPTH)) begin
          error_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          total_d = total32[CNT_W-1:0];
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (hs) begin
          wr_d      = 1'b1;
          wr_addr_d = wbase_q + count_q[ADDR_W-1:0];
          wr_data_d = bus.Pix_Data;
          count_d   = count_inc;
          if (count_inc == total_q) state_d = S_DONE;
        end
        if (abort_req) state_d = S_IDLE;
      end
      default: begin
        if (!abort_req) done_d = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and register bank
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= S_IDLE;
      base_q    <= '0;
      width_q   <= '0;
      height_q  <= '0;
      wbase_q   <= '0;
      wwidth_q  <= '0;
      wheight_q <= '0;
      total_q   <= '0;
      count_q   <= '0;
      irq_en_q  <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      wr_q      <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      width_q   <= width_d;
      height_q  <= height_d;
      wbase_q   <= wbase_d;
      wwidth_q  <= wwidth_d;
      wheight_q <= wheight_d;
      total_q   <= total_d;
      count_q   <= count_d;
      irq_en_q  <= irq_en_d;
      done_q    <= done_d;
      error_q   <= error_d;
      wr_q      <= wr_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      rdata_q   <= rdata_d;
    end
  end

  assign bus.Pix_Ready        = pix_ready;
  assign bus.MEM_Write        = wr_q;
  assign bus.MEM_Addr         = wr_addr_q;
  assign bus.MEM_WriteData    = wr_data_q;
  assign bus.Busy             = busy;
  assign bus.IRQ              = done_q & irq_en_q;
  assign bus.AVL_CSR_ReadData = rdata_q;
  assign dbg_state            = state_q;
endmodule

// File: tb/tb_sprite_mem_loader.sv
// Directed bench for sprite_mem_loader: CSR driver tasks, pixel stream
// driver, write monitor with an expected-write queue, final report.
module tb_sprite_mem_loader;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;

  logic       Clk;
  logic       Reset_n;
  logic [1:0] dbg_state;

  sprite_mem_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  sprite_mem_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_DEPTH(4096)) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // ---------------- scoreboard state ----------------
  logic [ADDR_W+DATA_W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int n_writes = 0;
  logic prev_hs = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  // Write monitor: every write must follow a handshake by exactly one cycle
  // and match the oldest expected {addr,data}.
  always @(negedge Clk) begin
    if (!Reset_n) begin
      prev_hs = 1'b0;
    end else begin
      if (bus.MEM_Write || prev_hs) chk("wr_latency", 32'(bus.MEM_Write), 32'(prev_hs));
      if (bus.MEM_Write) begin
        n_writes++;
        n_checks++;
        assert (exp_q.size() != 0) begin
          n_pass++;
          chk("wr_addr_data", 32'({bus.MEM_Addr, bus.MEM_WriteData}), 32'(exp_q.pop_front()));
        end else $error("FAIL wr_unexpected: observed addr=0x%03h expected no write", bus.MEM_Addr);
      end
      prev_hs = bus.Pix_Valid && bus.Pix_Ready;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic csr_write(input logic [1:0] a, input logic [31:0] d);
    bus.AVL_CSR_Address   = a;
    bus.AVL_CSR_WriteData = d;
    bus.AVL_CSR_Write     = 1'b1;
    @(posedge Clk); #1;
    bus.AVL_CSR_Write     = 1'b0;
  endtask

  task automatic csr_read(input logic [1:0] a, output logic [31:0] d);
    bus.AVL_CSR_Address = a;
    bus.AVL_CSR_Read    = 1'b1;
    @(posedge Clk); #1;
    bus.AVL_CSR_Read    = 1'b0;
    d = bus.AVL_CSR_ReadData;
  endtask

  // Offers one pixel; leaves Pix_Valid high so calls can run back to back.
  task automatic send_pix(input logic [DATA_W-1:0] d, input logic [ADDR_W-1:0] a);
    logic got;
    got = 1'b0;
    bus.Pix_Valid = 1'b1;
    bus.Pix_Data  = d;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge Clk);
      if (bus.Pix_Ready) got = 1'b1;
    end
    if (got) begin
      exp_q.push_back({a, d});
      @(posedge Clk); #1;
    end else begin
      chk("pix_accept_timeout", 32'(got), 32'd1);
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [31:0] rd;
    int w0;
    int busy_cycles;
    logic [DATA_W-1:0] px;

    bus.AVL_CSR_Address   = '0;
    bus.AVL_CSR_Read      = 1'b0;
    bus.AVL_CSR_Write     = 1'b0;
    bus.AVL_CSR_WriteData = '0;
    bus.Pix_Valid         = 1'b0;
    bus.Pix_Data          = '0;
    Reset_n               = 1'b0;

    // Reset state
    #12;
    chk("rst_pix_ready", 32'(bus.Pix_Ready), 32'd0);
    chk("rst_mem_write", 32'(bus.MEM_Write), 32'd0);
    chk("rst_busy",      32'(bus.Busy), 32'd0);
    chk("rst_irq",       32'(bus.IRQ), 32'd0);
    chk("rst_rdata",     bus.AVL_CSR_ReadData, 32'd0);
    chk("rst_state",     32'(dbg_state), 32'd0);
    idle_cycles(2);
    Reset_n = 1'b1;
    idle_cycles(1);
    csr_read(2'd3, rd);
    chk("rst_status", rd, 32'd0);

    // Load 1: W4/H2 at 0x100, back-to-back pixels, IRQ enabled
    csr_write(2'd0, 32'h4);
    csr_write(2'd1, 32'h100);
    csr_write(2'd2, {16'd2, 16'd4});
    w0 = n_writes;
    csr_write(2'd0, 32'h5);
    for (int i = 0; i < 8; i++) send_pix(DATA_W'((i + 1) * 16'h1111), ADDR_W'(12'h100 + i));
    bus.Pix_Valid = 1'b0;
    idle_cycles(3);
    chk("l1_writes",    32'(n_writes - w0), 32'd8);
    chk("l1_pix_ready", 32'(bus.Pix_Ready), 32'd0);
    chk("l1_irq",       32'(bus.IRQ), 32'd1);
    csr_read(2'd3, rd);
    chk("l1_status", rd, 32'h0008_0002);

    // Load 2: same size, gapped stream with random pixels (zero included)
    w0 = n_writes;
    csr_write(2'd0, 32'h5);
    chk("l2_irq_cleared_by_start", 32'(bus.IRQ), 32'd0);
    for (int i = 0; i < 8; i++) begin
      px = (i == 3) ? 16'h0000 : DATA_W'($urandom_range(1, 16'hFFFF));
      send_pix(px, ADDR_W'(12'h100 + i));
      bus.Pix_Valid = 1'b0;
      idle_cycles(1);
    end
    idle_cycles(3);
    chk("l2_writes", 32'(n_writes - w0), 32'd8);
    chk("l2_irq",    32'(bus.IRQ), 32'd1);
    csr_write(2'd3, 32'h2);
    chk("l2_irq_w1c", 32'(bus.IRQ), 32'd0);

    // Out-of-range size: 64*64 at base 1 overruns memory by one word
    csr_write(2'd1, 32'h1);
    csr_write(2'd2, {16'd64, 16'd64});
    w0 = n_writes;
    csr_write(2'd0, 32'h5);
    busy_cycles = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      if (bus.Busy) busy_cycles++;
    end
    chk("err1_busy_cycles", 32'(busy_cycles), 32'd1);
    chk("err1_writes", 32'(n_writes - w0), 32'd0);
    idle_cycles(1);
    csr_read(2'd3, rd);
    chk("err1_status", rd, 32'h0000_0004);

    // Zero width
    csr_write(2'd2, {16'd5, 16'd0});
    csr_write(2'd0, 32'h5);
    idle_cycles(4);
    chk("err2_writes", 32'(n_writes - w0), 32'd0);
    csr_read(2'd3, rd);
    chk("err2_status", rd, 32'h0000_0004);

    // Abort after 5 of 16 pixels
    csr_write(2'd1, 32'h0);
    csr_write(2'd2, {16'd1, 16'd16});
    w0 = n_writes;
    csr_write(2'd0, 32'h5);
    for (int i = 0; i < 5; i++) send_pix(DATA_W'(16'hA000 + i), ADDR_W'(i));
    bus.Pix_Valid = 1'b0;
    csr_write(2'd0, 32'h6);
    idle_cycles(2);
    chk("abort_writes",    32'(n_writes - w0), 32'd5);
    chk("abort_busy",      32'(bus.Busy), 32'd0);
    chk("abort_pix_ready", 32'(bus.Pix_Ready), 32'd0);
    chk("abort_irq",       32'(bus.IRQ), 32'd0);
    csr_read(2'd3, rd);
    chk("abort_status", rd, 32'h0005_0000);
    bus.Pix_Valid = 1'b1;
    bus.Pix_Data  = 16'hDEAD;
    idle_cycles(3);
    bus.Pix_Valid = 1'b0;
    chk("abort_no_accept", 32'(n_writes - w0), 32'd5);

    // START and ABORT together
    csr_write(2'd0, 32'h3);
    chk("sa_busy",  32'(bus.Busy), 32'd0);
    chk("sa_state", 32'(dbg_state), 32'd0);
    idle_cycles(1);
    chk("sa_state_later", 32'(dbg_state), 32'd0);

    // START and BASE writes during LOAD are ignored
    csr_write(2'd1, 32'h200);
    csr_write(2'd2, {16'd1, 16'd4});
    w0 = n_writes;
    csr_write(2'd0, 32'h5);
    for (int i = 0; i < 2; i++) send_pix(DATA_W'(16'hB000 + i), ADDR_W'(12'h200 + i));
    bus.Pix_Valid = 1'b0;
    csr_write(2'd0, 32'h5);
    csr_write(2'd1, 32'h300);
    for (int i = 2; i < 4; i++) send_pix(DATA_W'(16'hB000 + i), ADDR_W'(12'h200 + i));
    bus.Pix_Valid = 1'b0;
    idle_cycles(3);
    chk("midstart_writes", 32'(n_writes - w0), 32'd4);
    csr_read(2'd3, rd);
    chk("midstart_status", rd, 32'h0004_0002);
    csr_read(2'd1, rd);
    chk("midbase_read", rd, 32'h200);

    // Reset during LOAD
    csr_write(2'd1, 32'h10);
    csr_write(2'd2, {16'd1, 16'd8});
    csr_write(2'd0, 32'h5);
    for (int i = 0; i < 3; i++) send_pix(DATA_W'(16'hC000 + i), ADDR_W'(12'h10 + i));
    #2;
    Reset_n = 1'b0;
    #1;
    chk("mrst_mem_write", 32'(bus.MEM_Write), 32'd0);
    chk("mrst_pix_ready", 32'(bus.Pix_Ready), 32'd0);
    chk("mrst_busy",      32'(bus.Busy), 32'd0);
    chk("mrst_irq",       32'(bus.IRQ), 32'd0);
    chk("mrst_rdata",     bus.AVL_CSR_ReadData, 32'd0);
    chk("mrst_addr",      32'(bus.MEM_Addr), 32'd0);
    bus.Pix_Valid = 1'b0;
    exp_q.delete();
    idle_cycles(2);
    Reset_n = 1'b1;
    idle_cycles(1);
    csr_read(2'd1, rd);
    chk("mrst_base_cleared", rd, 32'd0);

    // Load that ends exactly at the top of memory
    csr_write(2'd1, 32'hFFE);
    csr_write(2'd2, {16'd1, 16'd2});
    w0 = n_writes;
    csr_write(2'd0, 32'h1);
    send_pix(16'h1234, 12'hFFE);
    send_pix(16'h5678, 12'hFFF);
    bus.Pix_Valid = 1'b0;
    idle_cycles(3);
    chk("top_writes", 32'(n_writes - w0), 32'd2);
    chk("top_irq_disabled", 32'(bus.IRQ), 32'd0);
    csr_read(2'd3, rd);
    chk("top_status", rd, 32'h0002_0002);

    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
